// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
//   Shares one async_transmitter between NUM_REQ byte-stream requesters.
//   Grants are round-robin and packet-locked: the holder keeps the
//   transmitter until it sends a byte marked last, until MAX_BURST bytes have
//   gone out, or until it leaves req_valid low for HOLD_TIMEOUT cycles.
//
// Ports
//   clk, rst     : single clock, synchronous active-high reset
//   req_valid    : per-lane byte available
//   req_data     : lane i occupies bits [8i+7:8i]
//   req_last     : per-lane end-of-packet marker for the byte on the lane
//   req_ready    : one-cycle pulse, byte on the granted lane consumed
//   tx_start     : to TxD_start (single-cycle pulse)
//   tx_data      : to TxD_data (registered, held until the next launch)
//   tx_busy      : from TxD_busy
//   grant_valid  : a requester currently holds the transmitter
//   grant_id     : index of the holder, 0 when no grant
//   pkt_split    : one-cycle pulse when a grant ends by burst limit or timeout
module uart_tx_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int MAX_BURST    = 16,
  parameter int HOLD_TIMEOUT = 1024
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [8*NUM_REQ-1:0]       req_data,
  input  logic [NUM_REQ-1:0]         req_last,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic                       tx_start,
  output logic [7:0]                 tx_data,
  input  logic                       tx_busy,
  output logic                       grant_valid,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       pkt_split
);

  localparam int ID_W   = $clog2(NUM_REQ);
  localparam int SUM_W  = ID_W + 1;
  localparam int HOLD_W = $clog2(HOLD_TIMEOUT + 1);

  localparam logic [7:0]        BURST_LIMIT = 8'(MAX_BURST);
  localparam logic [HOLD_W-1:0] HOLD_LAST   = HOLD_W'(HOLD_TIMEOUT - 1);
  localparam logic [ID_W-1:0]   LAST_ID     = ID_W'(NUM_REQ - 1);
  localparam logic [SUM_W-1:0]  NUM_REQ_S   = SUM_W'(NUM_REQ);

  typedef enum logic [2:0] {
    IDLE,
    LAUNCH,
    WAIT_BUSY,
    WAIT_DONE,
    HOLD
  } state_t;

  state_t state, nextState;

  // Registered datapath
  logic [ID_W-1:0]   rrPtr;
  logic              grantValid;
  logic [ID_W-1:0]   grantId;
  logic [7:0]        burstCnt;
  logic              lastSeen;
  logic [HOLD_W-1:0] holdCnt;
  logic [7:0]        txDataReg;

  // Control strobes from the next-state logic
  logic doGrant;
  logic doLaunch;
  logic doRelease;
  logic doSplit;
  logic holdClr;
  logic holdInc;

  // Arbitration
  logic [2*NUM_REQ-1:0] validTwice;
  logic [NUM_REQ-1:0]   rotValid;
  logic [SUM_W-1:0]     offset;
  logic [SUM_W-1:0]     ptrSum;
  logic                 hit;
  logic                 winnerFound;
  logic [ID_W-1:0]      winnerId;
  logic [7:0]           winnerData;

  // Granted lane view
  logic [7:0]      grantData;
  logic            grantReqValid;
  logic [ID_W-1:0] nextPtr;

  // Rotating the doubled valid vector by rrPtr turns the wrap-around search
  // into a plain lowest-set-bit search; the offset is added back modulo
  // NUM_REQ to recover the lane index.
  always_comb begin
    validTwice = {req_valid, req_valid};
    rotValid   = validTwice[int'(rrPtr) +: NUM_REQ];
    hit        = 1'b0;
    offset     = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (!hit && rotValid[i]) begin
        hit    = 1'b1;
        offset = SUM_W'(i);
      end
    end
    winnerFound = hit;
    ptrSum      = {1'b0, rrPtr} + offset;
    if (ptrSum >= NUM_REQ_S) begin
      ptrSum = ptrSum - NUM_REQ_S;
    end
    winnerId   = ptrSum[ID_W-1:0];
    winnerData = req_data[8*int'(winnerId) +: 8];
  end

  always_comb begin
    grantData     = req_data[8*int'(grantId) +: 8];
    grantReqValid = req_valid[grantId];
    nextPtr       = (grantId == LAST_ID) ? '0 : grantId + 1'b1;
  end

  // State register and datapath
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      rrPtr      <= '0;
      grantValid <= 1'b0;
      grantId    <= '0;
      burstCnt   <= '0;
      lastSeen   <= 1'b0;
      holdCnt    <= '0;
      txDataReg  <= '0;
    end else begin
      state <= nextState;

      if (doGrant) begin
        grantValid <= 1'b1;
        grantId    <= winnerId;
        burstCnt   <= '0;
        lastSeen   <= 1'b0;
        txDataReg  <= winnerData;
      end

      if (doLaunch) begin
        txDataReg <= grantData;
      end

      if (state == LAUNCH) begin
        lastSeen <= req_last[grantId];
        burstCnt <= burstCnt + 8'd1;
      end

      if (holdClr) begin
        holdCnt <= '0;
      end else if (holdInc) begin
        holdCnt <= holdCnt + 1'b1;
      end

      if (doRelease) begin
        rrPtr      <= nextPtr;
        grantValid <= 1'b0;
        grantId    <= '0;
      end
    end
  end

  // Next-state logic
  always_comb begin
    nextState = state;
    doGrant   = 1'b0;
    doLaunch  = 1'b0;
    doRelease = 1'b0;
    doSplit   = 1'b0;
    holdClr   = 1'b0;
    holdInc   = 1'b0;

    unique case (state)
      IDLE: begin
        if (!tx_busy && winnerFound) begin
          doGrant   = 1'b1;
          nextState = LAUNCH;
        end
      end

      LAUNCH: begin
        nextState = WAIT_BUSY;
      end

      WAIT_BUSY: begin
        if (tx_busy) begin
          nextState = WAIT_DONE;
        end
      end

      WAIT_DONE: begin
        // last outranks the burst limit so a packet ending exactly at
        // MAX_BURST releases without a split pulse.
        if (!tx_busy) begin
          if (lastSeen) begin
            doRelease = 1'b1;
          end else if (burstCnt == BURST_LIMIT) begin
            doRelease = 1'b1;
            doSplit   = 1'b1;
          end else if (grantReqValid) begin
            doLaunch  = 1'b1;
            nextState = LAUNCH;
          end else begin
            holdClr   = 1'b1;
            nextState = HOLD;
          end
        end
      end

      HOLD: begin
        // A byte arriving in the final hold cycle still wins over the timeout.
        if (grantReqValid) begin
          doLaunch  = 1'b1;
          nextState = LAUNCH;
        end else if (holdCnt == HOLD_LAST) begin
          doRelease = 1'b1;
          doSplit   = 1'b1;
        end else begin
          holdInc = 1'b1;
        end
      end

      default: begin
        nextState = IDLE;
      end
    endcase

    if (doRelease) begin
      nextState = IDLE;
    end
  end

  // Output decode
  always_comb begin
    tx_start    = (state == LAUNCH);
    req_ready   = '0;
    if (state == LAUNCH) begin
      req_ready[grantId] = 1'b1;
    end
    tx_data     = txDataReg;
    grant_valid = grantValid;
    grant_id    = grantId;
    pkt_split   = doSplit;
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
module tb_uart_tx_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  req_valid = '0;
  logic [31:0] req_data  = '0;
  logic [3:0]  req_last  = '0;
  logic [3:0]  req_ready;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic        tx_busy = 1'b0;
  logic        grant_valid;
  logic [1:0]  grant_id;
  logic        pkt_split;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Requester lanes: byte queues with an optional stall after N bytes taken
  logic [8:0] laneMem [4][16];
  int laneHead [4];
  int laneTail [4];
  int laneTaken[4];
  int stallAt  [4];
  int stallLen [4];
  int holdOff  [4];

  // Transmitter model: busy for 10 cycles after each start
  int   busyCnt  = 0;
  logic busyPrev = 1'b0;

  // Event log
  int startCyc[$];
  int startId[$];
  int startData[$];
  int splitCyc[$];
  int fallCyc[$];
  int readyErr    = 0;
  int ready1First = -1;

  uart_tx_arbiter #(
    .NUM_REQ(4),
    .MAX_BURST(4),
    .HOLD_TIMEOUT(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .req_valid(req_valid),
    .req_data(req_data),
    .req_last(req_last),
    .req_ready(req_ready),
    .tx_start(tx_start),
    .tx_data(tx_data),
    .tx_busy(tx_busy),
    .grant_valid(grant_valid),
    .grant_id(grant_id),
    .pkt_split(pkt_split)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic int getAt(input int q[$], input int k);
    if (k >= 0 && k < q.size()) return q[k];
    return -1;
  endfunction

  task automatic clearLanes();
    for (int i = 0; i < 4; i++) begin
      laneHead[i]  = 0;
      laneTail[i]  = 0;
      laneTaken[i] = 0;
      stallAt[i]   = -1;
      stallLen[i]  = 0;
      holdOff[i]   = 0;
    end
  endtask

  task automatic clearLog();
    startCyc.delete();
    startId.delete();
    startData.delete();
    splitCyc.delete();
    fallCyc.delete();
  endtask

  task automatic pushByte(input int lane, input logic [7:0] d, input logic l);
    laneMem[lane][laneTail[lane]] = {l, d};
    laneTail[lane]++;
  endtask

  task automatic drive();
    for (int i = 0; i < 4; i++) begin
      if (laneHead[i] < laneTail[i] && holdOff[i] == 0) begin
        req_valid[i]          = 1'b1;
        req_data[8*i +: 8]    = laneMem[i][laneHead[i]][7:0];
        req_last[i]           = laneMem[i][laneHead[i]][8];
      end else begin
        req_valid[i] = 1'b0;
        req_last[i]  = 1'b0;
      end
    end
  endtask

  // One clock: sample at negedge, update requesters and transmitter after posedge.
  task automatic step();
    logic [3:0] rdy;
    logic       st;
    @(negedge clk);
    cyc++;
    rdy = req_ready;
    st  = tx_start;
    if (tx_start) begin
      startCyc.push_back(cyc);
      startId.push_back(int'(grant_id));
      startData.push_back(int'(tx_data));
    end
    if (pkt_split) splitCyc.push_back(cyc);
    if (busyPrev && !tx_busy) fallCyc.push_back(cyc);
    busyPrev = tx_busy;
    if (rdy != 4'd0 && (!st || rdy != (4'd1 << grant_id))) readyErr++;
    if (rdy[1] && ready1First < 0) ready1First = cyc;
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      if (holdOff[i] > 0) holdOff[i]--;
      if (rdy[i]) begin
        laneHead[i]++;
        laneTaken[i]++;
        if (laneTaken[i] == stallAt[i]) holdOff[i] = stallLen[i];
      end
    end
    if (st) busyCnt = 10;
    else if (busyCnt > 0) busyCnt--;
    tx_busy = (busyCnt != 0);
    drive();
  endtask

  task automatic doReset();
    clearLanes();
    drive();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    for (int n = 0; n < 20 && busyCnt != 0; n++) step();
    clearLog();
  endtask

  task automatic test_reset();
    checks++; if (tx_start !== 1'b0) begin errors++; $display("FAIL reset_tx_start got %0b exp 0", tx_start); end
    checks++; if (tx_data !== 8'h00) begin errors++; $display("FAIL reset_tx_data got %0h exp 0", tx_data); end
    checks++; if (req_ready !== 4'h0) begin errors++; $display("FAIL reset_req_ready got %0h exp 0", req_ready); end
    checks++; if (grant_valid !== 1'b0) begin errors++; $display("FAIL reset_grant_valid got %0b exp 0", grant_valid); end
    checks++; if (grant_id !== 2'd0) begin errors++; $display("FAIL reset_grant_id got %0d exp 0", grant_id); end
    checks++; if (pkt_split !== 1'b0) begin errors++; $display("FAIL reset_pkt_split got %0b exp 0", pkt_split); end
  endtask

  task automatic test_single();
    int expData[3] = '{8'h41, 8'h42, 8'h43};
    int rrId[4]    = '{3, 0, 1, 2};
    doReset();
    pushByte(2, 8'h41, 1'b0);
    pushByte(2, 8'h42, 1'b0);
    pushByte(2, 8'h43, 1'b1);
    drive();
    repeat (45) step();
    checks++; if (startId.size() != 3) begin errors++; $display("FAIL single_count got %0d exp 3", startId.size()); end
    for (int k = 0; k < 3; k++) begin
      checks++; if (getAt(startId, k) !== 2) begin errors++; $display("FAIL single_id[%0d] got %0d exp 2", k, getAt(startId, k)); end
      checks++; if (getAt(startData, k) !== expData[k]) begin errors++; $display("FAIL single_data[%0d] got %0h exp %0h", k, getAt(startData, k), expData[k]); end
    end
    checks++; if (getAt(startCyc, 1) - getAt(startCyc, 0) !== 12) begin errors++; $display("FAIL single_gap1 got %0d exp 12", getAt(startCyc, 1) - getAt(startCyc, 0)); end
    checks++; if (getAt(startCyc, 1) - getAt(fallCyc, 0) !== 1) begin errors++; $display("FAIL single_fall_to_start got %0d exp 1", getAt(startCyc, 1) - getAt(fallCyc, 0)); end
    checks++; if (splitCyc.size() != 0) begin errors++; $display("FAIL single_split got %0d exp 0", splitCyc.size()); end
    checks++; if (grant_valid !== 1'b0) begin errors++; $display("FAIL single_released got %0b exp 0", grant_valid); end
    // rr_ptr should now sit at 3: with all lanes valid, lane 3 goes first.
    clearLog();
    for (int i = 0; i < 4; i++) pushByte(i, 8'(8'h60 + i), 1'b1);
    drive();
    repeat (60) step();
    for (int k = 0; k < 4; k++) begin
      checks++; if (getAt(startId, k) !== rrId[k]) begin errors++; $display("FAIL single_rrptr_id[%0d] got %0d exp %0d", k, getAt(startId, k), rrId[k]); end
    end
  endtask

  task automatic test_round_robin();
    int expId[8]   = '{0, 1, 2, 3, 0, 1, 2, 3};
    int expData[8] = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h20, 8'h21, 8'h22, 8'h23};
    doReset();
    for (int i = 0; i < 4; i++) begin
      pushByte(i, 8'(8'h10 + i), 1'b1);
      pushByte(i, 8'(8'h20 + i), 1'b1);
    end
    drive();
    repeat (100) step();
    checks++; if (startId.size() != 8) begin errors++; $display("FAIL rr_count got %0d exp 8", startId.size()); end
    for (int k = 0; k < 8; k++) begin
      checks++; if (getAt(startId, k) !== expId[k]) begin errors++; $display("FAIL rr_id[%0d] got %0d exp %0d", k, getAt(startId, k), expId[k]); end
      checks++; if (getAt(startData, k) !== expData[k]) begin errors++; $display("FAIL rr_data[%0d] got %0h exp %0h", k, getAt(startData, k), expData[k]); end
    end
    checks++; if (getAt(startCyc, 1) - getAt(fallCyc, 0) !== 2) begin errors++; $display("FAIL rr_fall_to_start got %0d exp 2", getAt(startCyc, 1) - getAt(fallCyc, 0)); end
    checks++; if (getAt(startCyc, 5) - getAt(startCyc, 4) !== 13) begin errors++; $display("FAIL rr_spacing got %0d exp 13", getAt(startCyc, 5) - getAt(startCyc, 4)); end
    checks++; if (splitCyc.size() != 0) begin errors++; $display("FAIL rr_split got %0d exp 0", splitCyc.size()); end
  endtask

  task automatic test_burst();
    int expId[7]   = '{1, 1, 1, 1, 3, 1, 1};
    int expData[7] = '{8'h51, 8'h52, 8'h53, 8'h54, 8'h77, 8'h55, 8'h56};
    doReset();
    for (int b = 0; b < 6; b++) pushByte(1, 8'(8'h51 + b), (b == 5));
    pushByte(3, 8'h77, 1'b1);
    drive();
    repeat (95) step();
    checks++; if (startId.size() != 7) begin errors++; $display("FAIL burst_count got %0d exp 7", startId.size()); end
    for (int k = 0; k < 7; k++) begin
      checks++; if (getAt(startId, k) !== expId[k]) begin errors++; $display("FAIL burst_id[%0d] got %0d exp %0d", k, getAt(startId, k), expId[k]); end
      checks++; if (getAt(startData, k) !== expData[k]) begin errors++; $display("FAIL burst_data[%0d] got %0h exp %0h", k, getAt(startData, k), expData[k]); end
    end
    checks++; if (splitCyc.size() != 1) begin errors++; $display("FAIL burst_split_count got %0d exp 1", splitCyc.size()); end
    checks++; if (getAt(splitCyc, 0) - getAt(startCyc, 3) !== 11) begin errors++; $display("FAIL burst_split_time got %0d exp 11", getAt(splitCyc, 0) - getAt(startCyc, 3)); end
    checks++; if (getAt(startCyc, 4) - getAt(splitCyc, 0) !== 2) begin errors++; $display("FAIL burst_regrant got %0d exp 2", getAt(startCyc, 4) - getAt(splitCyc, 0)); end
    // last on exactly the MAX_BURST-th byte: normal release, no split
    clearLog();
    for (int b = 0; b < 4; b++) pushByte(2, 8'(8'h81 + b), (b == 3));
    drive();
    repeat (55) step();
    checks++; if (startId.size() != 4) begin errors++; $display("FAIL burst_exact_count got %0d exp 4", startId.size()); end
    checks++; if (getAt(startData, 3) !== 8'h84) begin errors++; $display("FAIL burst_exact_data got %0h exp 84", getAt(startData, 3)); end
    checks++; if (splitCyc.size() != 0) begin errors++; $display("FAIL burst_exact_split got %0d exp 0", splitCyc.size()); end
    checks++; if (grant_valid !== 1'b0) begin errors++; $display("FAIL burst_exact_release got %0b exp 0", grant_valid); end
  endtask

  task automatic test_timeout();
    int resId[4]    = '{0, 0, 0, 1};
    int resData[4]  = '{8'hA1, 8'hA2, 8'hA3, 8'hB1};
    int toId[4]     = '{0, 1, 0, 0};
    int toData[4]   = '{8'hA1, 8'hB1, 8'hA2, 8'hA3};
    // Resume in the last hold cycle: grant kept, no interleave
    doReset();
    pushByte(0, 8'hA1, 1'b0);
    pushByte(0, 8'hA2, 1'b0);
    pushByte(0, 8'hA3, 1'b1);
    pushByte(1, 8'hB1, 1'b1);
    stallAt[0]  = 1;
    stallLen[0] = 18;
    drive();
    repeat (70) step();
    for (int k = 0; k < 4; k++) begin
      checks++; if (getAt(startId, k) !== resId[k]) begin errors++; $display("FAIL resume_id[%0d] got %0d exp %0d", k, getAt(startId, k), resId[k]); end
      checks++; if (getAt(startData, k) !== resData[k]) begin errors++; $display("FAIL resume_data[%0d] got %0h exp %0h", k, getAt(startData, k), resData[k]); end
    end
    checks++; if (getAt(startCyc, 1) - getAt(startCyc, 0) !== 20) begin errors++; $display("FAIL resume_gap got %0d exp 20", getAt(startCyc, 1) - getAt(startCyc, 0)); end
    checks++; if (splitCyc.size() != 0) begin errors++; $display("FAIL resume_split got %0d exp 0", splitCyc.size()); end
    // Stall too long: revoked with split, lane 1 granted, lane 0 resumes later
    doReset();
    pushByte(0, 8'hA1, 1'b0);
    pushByte(0, 8'hA2, 1'b0);
    pushByte(0, 8'hA3, 1'b1);
    pushByte(1, 8'hB1, 1'b1);
    stallAt[0]  = 1;
    stallLen[0] = 40;
    drive();
    repeat (75) step();
    for (int k = 0; k < 4; k++) begin
      checks++; if (getAt(startId, k) !== toId[k]) begin errors++; $display("FAIL timeout_id[%0d] got %0d exp %0d", k, getAt(startId, k), toId[k]); end
      checks++; if (getAt(startData, k) !== toData[k]) begin errors++; $display("FAIL timeout_data[%0d] got %0h exp %0h", k, getAt(startData, k), toData[k]); end
    end
    checks++; if (splitCyc.size() != 1) begin errors++; $display("FAIL timeout_split_count got %0d exp 1", splitCyc.size()); end
    checks++; if (getAt(splitCyc, 0) - getAt(startCyc, 0) !== 19) begin errors++; $display("FAIL timeout_split_time got %0d exp 19", getAt(splitCyc, 0) - getAt(startCyc, 0)); end
    checks++; if (getAt(startCyc, 1) - getAt(splitCyc, 0) !== 2) begin errors++; $display("FAIL timeout_regrant got %0d exp 2", getAt(startCyc, 1) - getAt(splitCyc, 0)); end
  endtask

  task automatic test_reset_mid();
    doReset();
    pushByte(2, 8'hC1, 1'b0);
    pushByte(2, 8'hC2, 1'b1);
    drive();
    for (int n = 0; n < 10 && startCyc.size() == 0; n++) step();
    repeat (4) step();
    pushByte(0, 8'hD1, 1'b1);
    drive();
    rst = 1'b1;
    step();
    rst = 1'b0;
    test_reset();
    repeat (30) step();
    checks++; if (startId.size() != 3) begin errors++; $display("FAIL rstmid_count got %0d exp 3", startId.size()); end
    checks++; if (getAt(startId, 1) !== 0) begin errors++; $display("FAIL rstmid_id got %0d exp 0", getAt(startId, 1)); end
    checks++; if (getAt(startData, 1) !== 8'hD1) begin errors++; $display("FAIL rstmid_data got %0h exp d1", getAt(startData, 1)); end
    checks++; if (getAt(startCyc, 1) - getAt(fallCyc, 0) !== 1) begin errors++; $display("FAIL rstmid_wait_busy got %0d exp 1", getAt(startCyc, 1) - getAt(fallCyc, 0)); end
    checks++; if (getAt(startData, 2) !== 8'hC2) begin errors++; $display("FAIL rstmid_lane2_resume got %0h exp c2", getAt(startData, 2)); end
  endtask

  task automatic test_isolation();
    int expId[4]   = '{0, 0, 0, 1};
    int expData[4] = '{8'hE1, 8'hE2, 8'hE3, 8'h5A};
    doReset();
    readyErr    = 0;
    ready1First = -1;
    pushByte(0, 8'hE1, 1'b0);
    pushByte(0, 8'hE2, 1'b0);
    pushByte(0, 8'hE3, 1'b1);
    pushByte(1, 8'h5A, 1'b1);
    drive();
    repeat (45) step();
    for (int k = 0; k < 4; k++) begin
      checks++; if (getAt(startId, k) !== expId[k]) begin errors++; $display("FAIL iso_id[%0d] got %0d exp %0d", k, getAt(startId, k), expId[k]); end
      checks++; if (getAt(startData, k) !== expData[k]) begin errors++; $display("FAIL iso_data[%0d] got %0h exp %0h", k, getAt(startData, k), expData[k]); end
    end
    checks++; if (readyErr !== 0) begin errors++; $display("FAIL iso_ready_misuse got %0d exp 0", readyErr); end
    checks++; if (ready1First !== getAt(startCyc, 3)) begin errors++; $display("FAIL iso_ready1_cycle got %0d exp %0d", ready1First, getAt(startCyc, 3)); end
  endtask

  initial begin
    clearLanes();
    doReset();
    test_reset();
    test_single();
    test_round_robin();
    test_burst();
    test_timeout();
    test_reset_mid();
    test_isolation();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
